// File: rtl/pll_phase_ctrl.sv
`timescale 1ns / 1ps
// Dynamic phase-shift sequencer for the ECP5 EHXPLLL.
// Waits for a filtered PLL lock, applies a boot-time phase offset, then serves
// runtime step requests one channel at a time. PHASESEL/PHASEDIR/PHASESTEP are
// driven from flops so the PLL never sees decode glitches.
module pll_phase_ctrl #(
  parameter int unsigned N_CH       = 3,
  parameter int unsigned STEP_W     = 8,
  parameter int unsigned VCO_STEPS  = 8,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned PULSE_CYC  = 2,
  parameter int unsigned GAP_CYC    = 2,
  parameter int unsigned LOCK_FILT  = 16,
  parameter int unsigned INIT_CHAN  = 1,
  parameter int unsigned INIT_STEPS = 0
) (
  input  logic                                  i_clk_in,
  input  logic                                  i_rst_n,
  input  logic                                  i_pll_lock,
  input  logic                                  i_req_valid,
  output logic                                  o_req_ready,
  input  logic [1:0]                            i_req_chan,
  input  logic                                  i_req_dir,
  input  logic [STEP_W-1:0]                     i_req_steps,
  output logic                                  o_done,
  output logic                                  o_err,
  output logic                                  o_clk_locked,
  output logic [N_CH*$clog2(VCO_STEPS)-1:0]     o_phase_pos,
  output logic [1:0]                            o_phasesel,
  output logic                                  o_phasedir,
  output logic                                  o_phasestep,
  output logic                                  o_phaseloadreg
);

  localparam int unsigned PW      = $clog2(VCO_STEPS);
  localparam int unsigned CW      = $clog2(LOCK_FILT + 1);
  localparam int unsigned TMR_MAX = (SETUP_CYC > PULSE_CYC) ?
                                    ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                                    ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
  localparam int unsigned TW      = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;

  typedef enum logic [2:0] {
    StWaitLock,
    StInit,
    StIdle,
    StSetup,
    StStepHi,
    StStepLo,
    StDone
  } state_e;

  state_e                     r_state, w_state_nxt;
  logic                       r_lock_meta, r_lock_sync;
  logic [CW-1:0]              r_lock_cnt, w_lock_cnt_nxt;
  logic [TW-1:0]              r_tmr, w_tmr_nxt;
  logic [STEP_W-1:0]          r_rem, w_rem_nxt;
  logic [1:0]                 r_chan, w_chan_nxt;
  logic                       r_dir, w_dir_nxt;
  logic                       r_boot, w_boot_nxt;
  logic                       r_err, w_err_nxt;
  logic                       r_clk_locked, w_clk_locked_nxt;
  logic [N_CH-1:0][PW-1:0]    r_pos, w_pos_nxt;
  logic [1:0]                 r_phasesel;
  logic                       r_phasedir;
  logic                       r_phasestep;
  logic                       w_hs;

  // Two-flop synchroniser for the asynchronous PLL lock pin
  always_ff @(posedge i_clk_in or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= i_pll_lock;
      r_lock_sync <= r_lock_meta;
    end
  end

  // Ready is gated by lock so a request is never accepted on the cycle we abort
  assign o_req_ready    = (r_state == StIdle) && r_lock_sync;
  assign w_hs           = i_req_valid && o_req_ready;
  assign o_done         = (r_state == StDone);
  assign o_err          = r_err;
  assign o_clk_locked   = r_clk_locked;
  assign o_phase_pos    = r_pos;
  assign o_phasesel     = r_phasesel;
  assign o_phasedir     = r_phasedir;
  assign o_phasestep    = r_phasestep;
  assign o_phaseloadreg = 1'b0;

  // Next-state logic: lock filter, step sequencing, position tracking, lock-loss abort
  always_comb begin
    w_state_nxt      = r_state;
    w_lock_cnt_nxt   = '0;
    w_tmr_nxt        = r_tmr;
    w_rem_nxt        = r_rem;
    w_chan_nxt       = r_chan;
    w_dir_nxt        = r_dir;
    w_boot_nxt       = r_boot;
    w_err_nxt        = 1'b0;
    w_clk_locked_nxt = r_clk_locked;
    w_pos_nxt        = r_pos;

    case (r_state)
      StWaitLock: begin
        if (r_lock_sync) begin
          w_lock_cnt_nxt = r_lock_cnt + 1'b1;
          if (r_lock_cnt == CW'(LOCK_FILT - 1)) begin
            if (INIT_STEPS > 0) begin
              w_state_nxt = StInit;
            end else begin
              w_state_nxt      = StIdle;
              w_clk_locked_nxt = 1'b1;
            end
          end
        end
      end
      StInit: begin
        w_chan_nxt  = 2'(INIT_CHAN);
        w_dir_nxt   = 1'b0;
        w_rem_nxt   = STEP_W'(INIT_STEPS);
        w_boot_nxt  = 1'b1;
        w_tmr_nxt   = TW'(SETUP_CYC);
        w_state_nxt = StSetup;
      end
      StIdle: begin
        if (w_hs) begin
          if (32'(i_req_chan) >= N_CH) begin
            w_err_nxt = 1'b1;
          end else begin
            w_chan_nxt = i_req_chan;
            w_dir_nxt  = i_req_dir;
            w_rem_nxt  = i_req_steps;
            w_boot_nxt = 1'b0;
            if (i_req_steps == '0) begin
              w_state_nxt = StDone;
            end else begin
              w_tmr_nxt   = TW'(SETUP_CYC);
              w_state_nxt = StSetup;
            end
          end
        end
      end
      // One extra cycle here loads the PHASESEL/PHASEDIR flops, so they are
      // then stable for SETUP_CYC full cycles before PHASESTEP rises
      StSetup: begin
        if (r_tmr == '0) begin
          w_tmr_nxt   = TW'(PULSE_CYC - 1);
          w_state_nxt = StStepHi;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end
      StStepHi: begin
        if (r_tmr == '0) begin
          w_rem_nxt = r_rem - 1'b1;
          for (int i = 0; i < N_CH; i++) begin
            if (r_chan == 2'(i)) begin
              if (r_dir) begin
                w_pos_nxt[i] = (r_pos[i] == '0) ? PW'(VCO_STEPS - 1) : r_pos[i] - 1'b1;
              end else begin
                w_pos_nxt[i] = (r_pos[i] == PW'(VCO_STEPS - 1)) ? '0 : r_pos[i] + 1'b1;
              end
            end
          end
          w_tmr_nxt   = TW'(GAP_CYC - 1);
          w_state_nxt = StStepLo;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end
      StStepLo: begin
        if (r_tmr == '0) begin
          if (r_rem != '0) begin
            w_tmr_nxt   = TW'(PULSE_CYC - 1);
            w_state_nxt = StStepHi;
          end else begin
            w_state_nxt = StDone;
          end
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end
      StDone: begin
        if (r_boot) begin
          w_clk_locked_nxt = 1'b1;
        end
        w_boot_nxt  = 1'b0;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StWaitLock;
    endcase

    // Lock loss: the PLL restarts at zero phase, so any step in progress is void
    if ((r_state != StWaitLock) && !r_lock_sync) begin
      w_state_nxt      = StWaitLock;
      w_lock_cnt_nxt   = '0;
      w_clk_locked_nxt = 1'b0;
      w_pos_nxt        = '0;
      w_boot_nxt       = 1'b0;
      w_err_nxt        = (r_state == StInit) || (r_state == StSetup) ||
                         (r_state == StStepHi) || (r_state == StStepLo);
    end
  end

  // State and datapath registers; PLL control pins are registered here
  always_ff @(posedge i_clk_in or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StWaitLock;
      r_lock_cnt   <= '0;
      r_tmr        <= '0;
      r_rem        <= '0;
      r_chan       <= '0;
      r_dir        <= 1'b0;
      r_boot       <= 1'b0;
      r_err        <= 1'b0;
      r_clk_locked <= 1'b0;
      r_pos        <= '0;
      r_phasesel   <= '0;
      r_phasedir   <= 1'b0;
      r_phasestep  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lock_cnt   <= w_lock_cnt_nxt;
      r_tmr        <= w_tmr_nxt;
      r_rem        <= w_rem_nxt;
      r_chan       <= w_chan_nxt;
      r_dir        <= w_dir_nxt;
      r_boot       <= w_boot_nxt;
      r_err        <= w_err_nxt;
      r_clk_locked <= w_clk_locked_nxt;
      r_pos        <= w_pos_nxt;
      if (r_state == StSetup) begin
        r_phasesel <= r_chan;
        r_phasedir <= r_dir;
      end
      r_phasestep  <= (w_state_nxt == StStepHi);
    end
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
`timescale 1ns / 1ps
// Directed bench for pll_phase_ctrl: boot offset, a table of step requests,
// back-to-back requests, lock loss mid-request and asynchronous reset mid-pulse.
module tb_pll_phase_ctrl;

  localparam int unsigned N_CH       = 3;
  localparam int unsigned STEP_W     = 8;
  localparam int unsigned VCO_STEPS  = 8;
  localparam int unsigned SETUP_CYC  = 2;
  localparam int unsigned PULSE_CYC  = 2;
  localparam int unsigned GAP_CYC    = 2;
  localparam int unsigned LOCK_FILT  = 16;
  localparam int unsigned INIT_CHAN  = 1;
  localparam int unsigned INIT_STEPS = 6;
  // 2 sync + 16 filter + INIT + (1+2+6*4+1) boot sequence, clk_locked one cycle after done
  localparam int BOOT_DONE_LAT = 46;
  localparam int BOOT_LOCK_LAT = 47;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pll_lock = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_chan = '0;
  logic              req_dir = 1'b0;
  logic [STEP_W-1:0] req_steps = '0;
  logic              done, err, clk_locked;
  logic [8:0]        phase_pos;
  logic [1:0]        phasesel;
  logic              phasedir, phasestep, phaseloadreg;

  pll_phase_ctrl #(
    .N_CH      (N_CH),
    .STEP_W    (STEP_W),
    .VCO_STEPS (VCO_STEPS),
    .SETUP_CYC (SETUP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .GAP_CYC   (GAP_CYC),
    .LOCK_FILT (LOCK_FILT),
    .INIT_CHAN (INIT_CHAN),
    .INIT_STEPS(INIT_STEPS)
  ) u_dut (
    .i_clk_in      (clk),
    .i_rst_n       (rst_n),
    .i_pll_lock    (pll_lock),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_chan    (req_chan),
    .i_req_dir     (req_dir),
    .i_req_steps   (req_steps),
    .o_done        (done),
    .o_err         (err),
    .o_clk_locked  (clk_locked),
    .o_phase_pos   (phase_pos),
    .o_phasesel    (phasesel),
    .o_phasedir    (phasedir),
    .o_phasestep   (phasestep),
    .o_phaseloadreg(phaseloadreg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pos_vec(input int p0, input int p1, input int p2);
    return p0 | (p1 << 3) | (p2 << 6);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // PHASESTEP waveform monitor: setup stability, pulse and gap widths
  bit         allow_short = 1'b0;
  int         n_rise = 0;
  int         hi_len = 0, lo_len = 0, stable = 0;
  bit         seen_fall = 1'b0;
  logic       prev_step = 1'b0;
  logic [1:0] prev_sel = '0;
  logic       prev_dir = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_step = 1'b0;
      hi_len    = 0;
      lo_len    = 0;
      stable    = 0;
      seen_fall = 1'b0;
      prev_sel  = phasesel;
      prev_dir  = phasedir;
    end else begin
      if (phasesel != prev_sel || phasedir != prev_dir) stable = 1;
      else stable++;
      if (phasestep && !prev_step) begin
        n_rise++;
        chk("setup_stable_before_rise", int'(stable - 1 >= int'(SETUP_CYC)), 1);
        if (seen_fall && !allow_short) chk("gap_width", int'(lo_len >= int'(GAP_CYC)), 1);
        hi_len = 1;
      end else if (!phasestep && prev_step) begin
        if (!allow_short) chk("pulse_width", hi_len, int'(PULSE_CYC));
        chk("sel_stable_during_pulse", int'(stable > hi_len), 1);
        seen_fall = 1'b1;
        lo_len    = 1;
      end else if (phasestep) begin
        hi_len++;
      end else begin
        lo_len++;
      end
      prev_step = phasestep;
      prev_sel  = phasesel;
      prev_dir  = phasedir;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] chan;
    logic       dir;
    logic [7:0] steps;
    bit         exp_err;
    int         exp_lat;
    int         exp_pos;
  } vec_t;

  vec_t vec[7];

  initial begin
    int cnt, done_at, r0, lat, hs, dn;

    // Positions after boot are (0,6,0); each row builds on the previous one
    vec[0] = '{2'd2, 1'b1, 8'd3, 1'b0, 16, pos_vec(0, 6, 5)};
    vec[1] = '{2'd0, 1'b0, 8'd2, 1'b0, 12, pos_vec(2, 6, 5)};
    vec[2] = '{2'd1, 1'b0, 8'd3, 1'b0, 16, pos_vec(2, 1, 5)};
    vec[3] = '{2'd0, 1'b1, 8'd0, 1'b0, 1,  pos_vec(2, 1, 5)};
    vec[4] = '{2'd3, 1'b0, 8'd1, 1'b1, 1,  pos_vec(2, 1, 5)};
    vec[5] = '{2'd2, 1'b0, 8'd4, 1'b0, 20, pos_vec(2, 1, 1)};
    vec[6] = '{2'd1, 1'b1, 8'd2, 1'b0, 12, pos_vec(2, 7, 1)};

    // Reset values
    repeat (3) tick();
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_clk_locked", int'(clk_locked), 0);
    chk("rst_phase_pos", int'(phase_pos), 0);
    chk("rst_phasesel", int'(phasesel), 0);
    chk("rst_phasedir", int'(phasedir), 0);
    chk("rst_phasestep", int'(phasestep), 0);
    chk("rst_phaseloadreg", int'(phaseloadreg), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("prelock_ready", int'(req_ready), 0);

    // Boot offset after lock
    r0 = n_rise;
    pll_lock = 1'b1;
    cnt = 0;
    done_at = -1;
    while (!clk_locked && cnt < 200) begin
      tick();
      cnt++;
      if (done) done_at = cnt;
    end
    chk("boot_lock_latency", cnt, BOOT_LOCK_LAT);
    chk("boot_done_latency", done_at, BOOT_DONE_LAT);
    chk("boot_pulses", n_rise - r0, int'(INIT_STEPS));
    chk("boot_phase_pos", int'(phase_pos), pos_vec(0, 6, 0));
    chk("boot_phasesel", int'(phasesel), int'(INIT_CHAN));
    chk("boot_phasedir", int'(phasedir), 0);
    chk("boot_ready", int'(req_ready), 1);

    // Table of single requests
    for (int k = 0; k < 7; k++) begin
      lat = 0;
      while (!req_ready && lat < 50) begin
        tick();
        lat++;
      end
      req_chan  = vec[k].chan;
      req_dir   = vec[k].dir;
      req_steps = vec[k].steps;
      req_valid = 1'b1;
      r0 = n_rise;
      tick();
      req_valid = 1'b0;
      chk($sformatf("v%0d_ready_after_hs", k), int'(req_ready), int'(vec[k].exp_err));
      lat = 1;
      while (!done && !err && lat < 100) begin
        tick();
        lat++;
      end
      chk($sformatf("v%0d_latency", k), lat, vec[k].exp_lat);
      chk($sformatf("v%0d_done", k), int'(done), int'(!vec[k].exp_err));
      chk($sformatf("v%0d_err", k), int'(err), int'(vec[k].exp_err));
      tick();
      chk($sformatf("v%0d_phase_pos", k), int'(phase_pos), vec[k].exp_pos);
      chk($sformatf("v%0d_pulses", k), n_rise - r0,
          vec[k].exp_err ? 0 : int'(vec[k].steps));
      if (!vec[k].exp_err && vec[k].steps != 0) begin
        chk($sformatf("v%0d_phasesel", k), int'(phasesel), int'(vec[k].chan));
        chk($sformatf("v%0d_phasedir", k), int'(phasedir), int'(vec[k].dir));
      end
    end

    // req_valid held through two back-to-back 1-step requests (8 cycles each)
    req_chan  = 2'd0;
    req_dir   = 1'b0;
    req_steps = 8'd1;
    req_valid = 1'b1;
    hs = 0;
    dn = 0;
    cnt = 0;
    while (dn < 2 && cnt < 100) begin
      if (req_ready) hs++;
      tick();
      cnt++;
      if (done) dn++;
    end
    req_valid = 1'b0;
    chk("b2b_handshakes", hs, 2);
    chk("b2b_dones", dn, 2);
    chk("b2b_cycles", cnt, 17);
    tick();
    chk("b2b_phase_pos", int'(phase_pos), pos_vec(4, 7, 1));

    // Lock loss during the 2nd pulse of a 5-step request
    req_chan  = 2'd0;
    req_dir   = 1'b0;
    req_steps = 8'd5;
    req_valid = 1'b1;
    r0 = n_rise;
    tick();
    req_valid = 1'b0;
    allow_short = 1'b1;
    cnt = 0;
    while (!(n_rise - r0 == 2 && phasestep) && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("ll_reached_2nd_pulse", n_rise - r0, 2);
    pll_lock = 1'b0;
    cnt = 0;
    while (!err && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("ll_err", int'(err), 1);
    chk("ll_phasestep", int'(phasestep), 0);
    chk("ll_clk_locked", int'(clk_locked), 0);
    chk("ll_phase_pos", int'(phase_pos), 0);
    chk("ll_ready", int'(req_ready), 0);
    tick();
    chk("ll_err_one_cycle", int'(err), 0);
    allow_short = 1'b0;

    // Relock re-applies the boot offset
    r0 = n_rise;
    pll_lock = 1'b1;
    cnt = 0;
    while (!clk_locked && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("relock_latency", cnt, BOOT_LOCK_LAT);
    chk("relock_pulses", n_rise - r0, int'(INIT_STEPS));
    chk("relock_phase_pos", int'(phase_pos), pos_vec(0, 6, 0));

    // Asynchronous reset in the middle of a pulse
    req_chan  = 2'd2;
    req_dir   = 1'b0;
    req_steps = 8'd2;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    cnt = 0;
    while (!phasestep && cnt < 50) begin
      tick();
      cnt++;
    end
    chk("ar_pulse_seen", int'(phasestep), 1);
    allow_short = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_phasestep", int'(phasestep), 0);
    chk("ar_phase_pos", int'(phase_pos), 0);
    chk("ar_clk_locked", int'(clk_locked), 0);
    chk("ar_ready", int'(req_ready), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_after_release_phase_pos", int'(phase_pos), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
